// File: rtl/exec_cond_stage.sv
// Execute-stage condition unit: registers decode control bits, evaluates the ARM
// condition against the NZCV register and gates side effects and flag updates.
module exec_cond_stage #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_e,
    input  logic       flush_e,
    input  logic [3:0] cond_d,
    input  logic       pcsrc_d,
    input  logic       branch_d,
    input  logic       regwrite_d,
    input  logic       memwrite_d,
    input  logic [1:0] flagwrite_d,
    input  logic [3:0] alu_flags_e,
    output logic [3:0] flags_q,
    output logic       cond_ex_e,
    output logic       pcsrc_e,
    output logic       branch_taken_e,
    output logic       regwrite_e,
    output logic       memwrite_e
);

    localparam logic [3:0] COND_AL = 4'b1110;

    logic [3:0] cond_e_q,      cond_e_d;
    logic       pcsrc_e_q,     pcsrc_e_d;
    logic       branch_e_q,    branch_e_d;
    logic       regwrite_e_q,  regwrite_e_d;
    logic       memwrite_e_q,  memwrite_e_d;
    logic [1:0] flagwrite_e_q, flagwrite_e_d;
    logic [3:0] flags_d;

    // Code 15 is the reserved "never" encoding and must not pass.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n_s, z_s, c_s, v_s, p_s;
        n_s = nzcv[3];
        z_s = nzcv[2];
        c_s = nzcv[1];
        v_s = nzcv[0];
        case (cond)
            4'd0:    p_s = z_s;
            4'd1:    p_s = ~z_s;
            4'd2:    p_s = c_s;
            4'd3:    p_s = ~c_s;
            4'd4:    p_s = n_s;
            4'd5:    p_s = ~n_s;
            4'd6:    p_s = v_s;
            4'd7:    p_s = ~v_s;
            4'd8:    p_s = c_s & ~z_s;
            4'd9:    p_s = ~c_s | z_s;
            4'd10:   p_s = (n_s == v_s);
            4'd11:   p_s = (n_s != v_s);
            4'd12:   p_s = ~z_s & (n_s == v_s);
            4'd13:   p_s = z_s | (n_s != v_s);
            4'd14:   p_s = 1'b1;
            default: p_s = 1'b0;
        endcase
        return p_s;
    endfunction

    // Condition check and side-effect gating, combinational from the stage registers.
    always_comb begin
        cond_ex_e      = cond_pass(cond_e_q, flags_q);
        pcsrc_e        = pcsrc_e_q & cond_ex_e;
        branch_taken_e = (branch_e_q | pcsrc_e_q) & cond_ex_e;
        regwrite_e     = regwrite_e_q & cond_ex_e;
        memwrite_e     = memwrite_e_q & cond_ex_e;
    end

    // Next state of the execute-stage registers: reset, then flush, then stall.
    always_comb begin
        cond_e_d      = cond_e_q;
        pcsrc_e_d     = pcsrc_e_q;
        branch_e_d    = branch_e_q;
        regwrite_e_d  = regwrite_e_q;
        memwrite_e_d  = memwrite_e_q;
        flagwrite_e_d = flagwrite_e_q;
        if (reset || flush_e) begin
            cond_e_d      = COND_AL;
            pcsrc_e_d     = 1'b0;
            branch_e_d    = 1'b0;
            regwrite_e_d  = 1'b0;
            memwrite_e_d  = 1'b0;
            flagwrite_e_d = 2'b00;
        end else if (!stall_e) begin
            cond_e_d      = cond_d;
            pcsrc_e_d     = pcsrc_d;
            branch_e_d    = branch_d;
            regwrite_e_d  = regwrite_d;
            memwrite_e_d  = memwrite_d;
            flagwrite_e_d = flagwrite_d;
        end else begin
            cond_e_d      = cond_e_q;
        end
    end

    // Flag update belongs to the current instruction, so a flush does not block it.
    always_comb begin
        flags_d = flags_q;
        if (reset) begin
            flags_d = FLAG_RESET;
        end else if (!stall_e && cond_ex_e) begin
            if (flagwrite_e_q[1]) begin
                flags_d[3:2] = alu_flags_e[3:2];
            end else begin
                flags_d[3:2] = flags_q[3:2];
            end
            if (flagwrite_e_q[0]) begin
                flags_d[1:0] = alu_flags_e[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        cond_e_q      <= cond_e_d;
        pcsrc_e_q     <= pcsrc_e_d;
        branch_e_q    <= branch_e_d;
        regwrite_e_q  <= regwrite_e_d;
        memwrite_e_q  <= memwrite_e_d;
        flagwrite_e_q <= flagwrite_e_d;
        flags_q       <= flags_d;
    end

endmodule

// File: tb/tb_exec_cond_stage.sv
// Directed and random checks of exec_cond_stage against a behavioural pipeline model.
module tb_exec_cond_stage;

    logic       clk = 1'b0;
    logic       reset, stall_e, flush_e;
    logic [3:0] cond_d;
    logic       pcsrc_d, branch_d, regwrite_d, memwrite_d;
    logic [1:0] flagwrite_d;
    logic [3:0] alu_flags_e;
    logic [3:0] flags_q;
    logic       cond_ex_e, pcsrc_e, branch_taken_e, regwrite_e, memwrite_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the instruction sitting in execute plus the flag register.
    bit         m_valid = 1'b0;
    logic [3:0] m_cond, m_flags;
    logic       m_pc, m_br, m_rw, m_mw;
    logic [1:0] m_fw;

    exec_cond_stage #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .cond_d(cond_d), .pcsrc_d(pcsrc_d), .branch_d(branch_d),
        .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .flagwrite_d(flagwrite_d),
        .alu_flags_e(alu_flags_e), .flags_q(flags_q), .cond_ex_e(cond_ex_e),
        .pcsrc_e(pcsrc_e), .branch_taken_e(branch_taken_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e)
    );

    always #5 clk = ~clk;

    // Odd codes invert the test of the even code below them; 14 always, 15 never.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic p;
        #1;
        p = ref_pass(m_cond, m_flags);
        if (m_valid) begin
            chk("flags_q", flags_q, m_flags);
            chk("cond_ex_e", {3'b000, cond_ex_e}, {3'b000, p});
            chk("pcsrc_e", {3'b000, pcsrc_e}, {3'b000, m_pc & p});
            chk("branch_taken_e", {3'b000, branch_taken_e}, {3'b000, (m_br | m_pc) & p});
            chk("regwrite_e", {3'b000, regwrite_e}, {3'b000, m_rw & p});
            chk("memwrite_e", {3'b000, memwrite_e}, {3'b000, m_mw & p});
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1;
            m_flags = 4'b0000;
            m_cond = 4'd14; {m_pc, m_br, m_rw, m_mw} = 4'b0000; m_fw = 2'b00;
        end else begin
            if (!stall_e && p && m_fw[1]) m_flags[3:2] = alu_flags_e[3:2];
            if (!stall_e && p && m_fw[0]) m_flags[1:0] = alu_flags_e[1:0];
            if (flush_e) begin
                m_cond = 4'd14; {m_pc, m_br, m_rw, m_mw} = 4'b0000; m_fw = 2'b00;
            end else if (!stall_e) begin
                m_cond = cond_d; m_pc = pcsrc_d; m_br = branch_d;
                m_rw = regwrite_d; m_mw = memwrite_d; m_fw = flagwrite_d;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic pc, input logic br, input logic rw,
                         input logic mw, input logic [1:0] fw, input logic [3:0] alu,
                         input logic st, input logic fl, input logic rs);
        cond_d = c; pcsrc_d = pc; branch_d = br; regwrite_d = rw; memwrite_d = mw;
        flagwrite_d = fw; alu_flags_e = alu; stall_e = st; flush_e = fl; reset = rs;
        step();
    endtask

    task automatic nop(input logic [3:0] alu);
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, alu, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held two cycles with arbitrary inputs.
        for (int i = 0; i < 2; i++)
            issue(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        chk("rst_flags", flags_q, 4'b0000);
        chk("rst_cond_ex", {3'b000, cond_ex_e}, 4'd1);
        chk("rst_gated", {regwrite_e, memwrite_e, pcsrc_e, branch_taken_e}, 4'b0000);

        // Flag set then EQ, with Z set and with Z clear.
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("eq_flags", flags_q, 4'b0100);
        chk("eq_rw_pass", {3'b000, regwrite_e}, 4'd1);
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("eq_rw_fail", {3'b000, regwrite_e}, 4'd0);

        // Partial update of N,Z only.
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("part_all_ones", flags_q, 4'b1111);
        nop(4'b0000);
        chk("part_nz_only", flags_q, 4'b0011);

        // Stall three cycles with a store in execute, then stall plus flush.
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 4'b1010, 1'b1, 1'b0, 1'b0);
            chk("stall_mw", {3'b000, memwrite_e}, 4'd1);
            chk("stall_flags", flags_q, 4'b0011);
        end
        issue(4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b0);
        chk("stflush_mw", {3'b000, memwrite_e}, 4'd0);
        chk("stflush_flags", flags_q, 4'b0011);

        // Flush does not cancel the flag update of the instruction in execute.
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b1001, 1'b0, 1'b1, 1'b0);
        chk("flush_flags", flags_q, 4'b1001);

        // Condition sweep: every code against every flag value.
        for (int f = 0; f < 16; f++) begin
            issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'($urandom), 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                issue(4'(c), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                      (c == 0) ? 4'(f) : 4'($urandom), 1'b0, 1'b0, 1'b0);
                if (c == 15) chk("never", {3'b000, cond_ex_e}, 4'd0);
            end
        end

        // Conditional branch GT, failing then passing.
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("gt_fail", {3'b000, branch_taken_e}, 4'd0);
        issue(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        issue(4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("gt_pass", {3'b000, branch_taken_e}, 4'd1);

        // Random traffic, including mid-run resets.
        for (int i = 0; i < 600; i++)
            issue(($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 4'($urandom),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 49) == 0);
        nop(4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
